// File: rtl/imm_genie_pkg.sv
// Shared opcodes, format/state enums and defaults for the imm_genie pipeline.
// The IMM_GENIE_EXT_PREFIX_EN build uses the prefix state enum below.
package imm_genie_pkg;

    localparam int DATA_W_DEFAULT = 16;
    localparam int PFX_W_DEFAULT  = 12;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_ADDI = 4'b0100;
    localparam logic [3:0] OP_SI   = 4'b0101;
    localparam logic [3:0] OP_LW   = 4'b0111;
    localparam logic [3:0] OP_SW   = 4'b1000;
    localparam logic [3:0] OP_BEQ  = 4'b1001;
    localparam logic [3:0] OP_EXT  = 4'b1010;
    localparam logic [3:0] OP_JAL  = 4'b1100;
    localparam logic [3:0] OP_LUI  = 4'b1110;
    localparam logic [3:0] OP_LBI  = 4'b1111;

    typedef enum logic [2:0] {R, I4, B5, J8, LUI, LBI, SI} fmt_e;

    typedef enum logic {ST_IDLE, ST_PFX} pfx_state_e;

    // EXT is deliberately absent: it is either consumed by the prefix FSM or is a plain R beat.
    function automatic fmt_e op_fmt(input logic [3:0] op);
        case (op)
            OP_ADD:                return R;
            OP_ADDI, OP_LW, OP_SW: return I4;
            OP_BEQ:                return B5;
            OP_JAL:                return J8;
            OP_LUI:                return LUI;
            OP_LBI:                return LBI;
            OP_SI:                 return SI;
            default:               return R;
        endcase
    endfunction

endpackage

// File: rtl/imm_genie_pipe_if.sv
// Valid/ready bus between the fetch/decode register and the operand-select mux.
// Out_PfxDrop only ever pulses in the IMM_GENIE_EXT_PREFIX_EN build.
interface imm_genie_pipe_if #(
    parameter int DATA_W = imm_genie_pkg::DATA_W_DEFAULT
);
    logic              In_Valid;
    logic              In_Ready;
    logic [15:0]       In_Inst;
    logic              Out_Valid;
    logic              Out_Ready;
    logic [DATA_W-1:0] Out_Imm;
    logic [1:0]        Out_Si;
    logic [3:0]        Out_Opcode;
    logic              Out_PfxDrop;

    modport master (
        output In_Valid, In_Inst, Out_Ready,
        input  In_Ready, Out_Valid, Out_Imm, Out_Si, Out_Opcode, Out_PfxDrop
    );

    modport slave (
        input  In_Valid, In_Inst, Out_Ready,
        output In_Ready, Out_Valid, Out_Imm, Out_Si, Out_Opcode, Out_PfxDrop
    );
endinterface

// File: rtl/imm_genie_decode.sv
// Combinational immediate decode: opcode + In_Inst[11:4] (+ optional prefix) -> imm, si.
// The prefix inputs are driven only in the IMM_GENIE_EXT_PREFIX_EN build.
module imm_genie_decode
    import imm_genie_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int PFX_W  = PFX_W_DEFAULT
) (
    input  logic [3:0]        i_opcode,
    input  logic [7:0]        i_fld,
    input  logic [PFX_W-1:0]  i_pfx,
    input  logic              i_pfx_use,
    output logic [DATA_W-1:0] o_imm,
    output logic [1:0]        o_si
);

    // NOTE: every output gets a default first, so no path through the case infers a latch.
    always_comb begin
        o_imm = '0;
        o_si  = '0;
        // Signed size casts sign-extend when widening and keep the low bits when narrowing.
        case (op_fmt(i_opcode))
            I4:  o_imm = i_pfx_use ? DATA_W'($signed({i_pfx, i_fld[3:0]}))
                                   : DATA_W'($signed(i_fld[3:0]));
            B5:  o_imm = i_pfx_use ? DATA_W'($signed({i_pfx, i_fld[4:0]}))
                                   : DATA_W'($signed(i_fld[4:0]));
            J8:  o_imm = i_pfx_use ? DATA_W'($signed({i_pfx, i_fld}))
                                   : DATA_W'($signed(i_fld));
            LUI: o_imm = DATA_W'($signed({i_fld, 8'h00}));
            LBI: o_imm = DATA_W'(i_fld);
            SI: begin
                o_imm = DATA_W'(i_fld[3:0]);
                o_si  = i_fld[5:4];
            end
            default: o_imm = '0;
        endcase
    end

endmodule

// File: rtl/imm_genie_pipe.sv
// One-stage registered immediate generator with valid/ready handshake.
// Define IMM_GENIE_EXT_PREFIX_EN to enable the EXT prefix register, IDLE/PFX FSM and Out_PfxDrop.
module imm_genie_pipe
    import imm_genie_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int PFX_W  = PFX_W_DEFAULT
) (
    input logic             CLK,
    input logic             Reset,
    imm_genie_pipe_if.slave bus
);

    logic              w_in_ready;
    logic              w_in_fire;
    logic              w_emit;
    logic              w_pfx_use;
    logic [3:0]        w_opcode;
    logic [PFX_W-1:0]  w_pfx;
    logic [DATA_W-1:0] w_imm;
    logic [1:0]        w_si;

    logic              r_valid;
    logic [DATA_W-1:0] r_imm;
    logic [1:0]        r_si;
    logic [3:0]        r_opcode;

    assign w_opcode   = bus.In_Inst[3:0];
    assign w_in_ready = !r_valid || bus.Out_Ready;
    assign w_in_fire  = bus.In_Valid && w_in_ready;

`ifdef IMM_GENIE_EXT_PREFIX_EN
    pfx_state_e       r_state;
    pfx_state_e       w_state_nxt;
    logic [PFX_W-1:0] r_pfx;
    logic             r_pfx_drop;
    logic             w_pfx_load;
    logic             w_drop;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state    <= ST_IDLE;
            r_pfx      <= '0;
            r_pfx_drop <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pfx_drop <= w_drop;
            if (w_pfx_load) r_pfx <= bus.In_Inst[PFX_W+3:4];
        end
    end

    // EXT beats are swallowed; the FSM only moves on an accepted input transfer.
    always_comb begin
        w_state_nxt = r_state;
        w_emit      = w_in_fire;
        w_drop      = 1'b0;
        w_pfx_use   = 1'b0;
        w_pfx_load  = 1'b0;
        if (w_in_fire) begin
            if (w_opcode == OP_EXT) begin
                w_emit      = 1'b0;
                w_pfx_load  = 1'b1;
                w_state_nxt = ST_PFX;
                w_drop      = (r_state == ST_PFX);
            end else if (r_state == ST_PFX) begin
                w_state_nxt = ST_IDLE;
                if (op_fmt(w_opcode) inside {I4, B5, J8}) w_pfx_use = 1'b1;
                else                                      w_drop    = 1'b1;
            end
        end
    end

    assign w_pfx           = r_pfx;
    assign bus.Out_PfxDrop = r_pfx_drop;
`else
    logic w_unused_hi;

    assign w_emit          = w_in_fire;
    assign w_pfx_use       = 1'b0;
    assign w_pfx           = '0;
    assign bus.Out_PfxDrop = 1'b0;
    assign w_unused_hi     = ^bus.In_Inst[15:12];
`endif

    imm_genie_decode #(
        .DATA_W (DATA_W),
        .PFX_W  (PFX_W)
    ) u_decode (
        .i_opcode  (w_opcode),
        .i_fld     (bus.In_Inst[11:4]),
        .i_pfx     (w_pfx),
        .i_pfx_use (w_pfx_use),
        .o_imm     (w_imm),
        .o_si      (w_si)
    );

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_valid  <= 1'b0;
            r_imm    <= '0;
            r_si     <= '0;
            r_opcode <= '0;
        end else if (w_in_fire && w_emit) begin
            r_valid  <= 1'b1;
            r_imm    <= w_imm;
            r_si     <= w_si;
            r_opcode <= w_opcode;
        end else if (bus.Out_Ready) begin
            r_valid  <= 1'b0;
        end
    end

    assign bus.In_Ready   = w_in_ready;
    assign bus.Out_Valid  = r_valid;
    assign bus.Out_Imm    = r_imm;
    assign bus.Out_Si     = r_si;
    assign bus.Out_Opcode = r_opcode;

endmodule

// File: tb/tb_imm_genie_pipe.sv
// Bench for imm_genie_pipe: 16- and 32-bit instances share one directed stimulus stream.
// Expectations adapt to whether IMM_GENIE_EXT_PREFIX_EN is defined.
module tb_imm_genie_pipe;

`ifdef IMM_GENIE_EXT_PREFIX_EN
    localparam bit EXT_EN = 1'b1;
`else
    localparam bit EXT_EN = 1'b0;
`endif

    logic        CLK;
    logic        tb_reset;
    logic        tb_in_valid;
    logic [15:0] tb_inst;
    logic        tb_out_ready;

    int n_checks = 0;
    int n_pass   = 0;

    imm_genie_pipe_if #(.DATA_W(16)) if16 ();
    imm_genie_pipe_if #(.DATA_W(32)) if32 ();

    assign if16.In_Valid  = tb_in_valid;
    assign if16.In_Inst   = tb_inst;
    assign if16.Out_Ready = tb_out_ready;
    assign if32.In_Valid  = tb_in_valid;
    assign if32.In_Inst   = tb_inst;
    assign if32.Out_Ready = tb_out_ready;

    imm_genie_pipe #(.DATA_W(16)) u_dut16 (.CLK(CLK), .Reset(tb_reset), .bus(if16.slave));
    imm_genie_pipe #(.DATA_W(32)) u_dut32 (.CLK(CLK), .Reset(tb_reset), .bus(if32.slave));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    endtask

    // Immediate from the format rules as plain integer arithmetic, masked to w bits.
    function automatic longint model_imm(input logic [15:0] inst, input bit use_pfx,
                                         input logic [11:0] pfx, input int w);
        longint raw;
        int     n;
        bit     sgn;
        raw = 0;
        n   = 0;
        sgn = 1'b0;
        case (inst[3:0])
            4'h4, 4'h7, 4'h8: begin raw = longint'(inst[7:4]);        n = 4;  sgn = 1'b1; end
            4'h9:             begin raw = longint'(inst[8:4]);        n = 5;  sgn = 1'b1; end
            4'hC:             begin raw = longint'(inst[11:4]);       n = 8;  sgn = 1'b1; end
            4'hE:             begin raw = longint'(inst[11:4]) * 256; n = 16; sgn = 1'b1; end
            4'hF:             raw = longint'(inst[11:4]);
            4'h5:             raw = longint'(inst[7:4]);
            default:          raw = 0;
        endcase
        if (use_pfx) begin
            raw = longint'(pfx) * (longint'(1) << n) + raw;
            n   = n + 12;
        end
        if (sgn && raw >= (longint'(1) << (n - 1))) raw = raw - (longint'(1) << n);
        return raw & ((longint'(1) << w) - 1);
    endfunction

    logic        m_started = 1'b0;
    logic        m_valid, m_pend, m_drop;
    logic [11:0] m_pfx;
    logic [31:0] m_imm16, m_imm32;
    logic [1:0]  m_si;
    logic [3:0]  m_op;
    logic        m_in_ready, m_fire, m_is_ext, m_use_pfx;

    assign m_in_ready = !m_valid || tb_out_ready;
    assign m_fire     = tb_in_valid && m_in_ready;
    assign m_is_ext   = EXT_EN && (tb_inst[3:0] == 4'hA);
    assign m_use_pfx  = EXT_EN && m_pend && (tb_inst[3:0] inside {4'h4, 4'h7, 4'h8, 4'h9, 4'hC});

    always @(posedge CLK) begin
        m_started <= 1'b1;
        if (tb_reset) begin
            m_valid <= 1'b0;
            m_pend  <= 1'b0;
            m_pfx   <= '0;
            m_drop  <= 1'b0;
        end else begin
            m_drop <= m_fire && m_pend && (m_is_ext || !m_use_pfx);
            if (m_fire && m_is_ext) begin
                m_pend <= 1'b1;
                m_pfx  <= tb_inst[15:4];
            end else if (m_fire) begin
                m_pend <= 1'b0;
            end
            if (m_fire && !m_is_ext) begin
                m_valid <= 1'b1;
                m_imm16 <= 32'(model_imm(tb_inst, m_use_pfx, m_pfx, 16));
                m_imm32 <= 32'(model_imm(tb_inst, m_use_pfx, m_pfx, 32));
                m_si    <= (tb_inst[3:0] == 4'h5) ? tb_inst[9:8] : 2'b00;
                m_op    <= tb_inst[3:0];
            end else if (tb_out_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    always @(negedge CLK) begin
        if (m_started) begin
            check("in_ready16", 32'(if16.In_Ready), 32'(m_in_ready));
            check("in_ready32", 32'(if32.In_Ready), 32'(m_in_ready));
            check("out_valid16", 32'(if16.Out_Valid), 32'(m_valid));
            check("out_valid32", 32'(if32.Out_Valid), 32'(m_valid));
            check("pfx_drop16", 32'(if16.Out_PfxDrop), 32'(m_drop));
            check("pfx_drop32", 32'(if32.Out_PfxDrop), 32'(m_drop));
            if (m_valid) begin
                check("imm16", 32'(if16.Out_Imm), m_imm16);
                check("imm32", if32.Out_Imm, m_imm32);
                check("si16", 32'(if16.Out_Si), 32'(m_si));
                check("opcode16", 32'(if16.Out_Opcode), 32'(m_op));
                check("opcode32", 32'(if32.Out_Opcode), 32'(m_op));
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [15:0] inst);
        tb_in_valid = 1'b1;
        tb_inst     = inst;
        tick();
    endtask

    task automatic idle();
        tb_in_valid = 1'b0;
        tick();
    endtask

    logic [15:0] fmt_inst  [6] = '{16'h0134, 16'h23F4, 16'h9FC9, 16'hBF6C, 16'hD0DE, 16'hC4AF};
    logic [31:0] fmt_exp16 [6] = '{32'h0003, 32'hFFFF, 32'hFFFC, 32'hFFF6, 32'h0D00, 32'h004A};
    logic [31:0] fmt_exp32 [6] = '{32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFC,
                                   32'hFFFFFFF6, 32'h00000D00, 32'h0000004A};

    initial begin
        tb_reset     = 1'b1;
        tb_in_valid  = 1'b0;
        tb_inst      = '0;
        tb_out_ready = 1'b1;
        tick();
        tick();
        check("rst_valid", 32'(if16.Out_Valid), 32'h0);
        check("rst_imm", 32'(if16.Out_Imm), 32'h0);
        check("rst_si", 32'(if32.Out_Si), 32'h0);
        check("rst_drop", 32'(if32.Out_PfxDrop), 32'h0);
        tb_reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            send(fmt_inst[i]);
            check("fmt_valid", 32'(if16.Out_Valid), 32'h1);
            check("fmt_imm16", 32'(if16.Out_Imm), fmt_exp16[i]);
            check("fmt_imm32", if32.Out_Imm, fmt_exp32[i]);
        end
        idle();

        send(16'h21F5);
        check("si_imm", 32'(if16.Out_Imm), 32'd15);
        check("si_field", 32'(if16.Out_Si), 32'd1);
        send(16'h0060);
        check("r_imm", 32'(if16.Out_Imm), 32'd0);
        check("r_si", 32'(if16.Out_Si), 32'd0);
        idle();

        tb_out_ready = 1'b0;
        send(16'h0134);
        tb_inst = 16'h23F4;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold_imm", 32'(if16.Out_Imm), 32'h0003);
            check("bp_in_ready", 32'(if16.In_Ready), 32'h0);
        end
        tb_out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(if16.In_Ready), 32'h1);
        tick();
        check("bp_next_imm", 32'(if16.Out_Imm), 32'hFFFF);
        idle();

        send(16'hABCA);
        check("ext_beat_valid", 32'(if32.Out_Valid), EXT_EN ? 32'h0 : 32'h1);
        send(16'h0054);
        check("ext_i4_imm32", if32.Out_Imm, EXT_EN ? 32'hFFFFABC5 : 32'h00000005);
        check("ext_i4_imm16", 32'(if16.Out_Imm), EXT_EN ? 32'hABC5 : 32'h0005);
        idle();

        send(16'h123A);
        send(16'hC4AF);
        check("drop_lbi_imm", 32'(if16.Out_Imm), 32'h004A);
        check("drop_lbi_pulse", 32'(if16.Out_PfxDrop), EXT_EN ? 32'h1 : 32'h0);
        idle();

        send(16'h111A);
        check("ext_first_nodrop", 32'(if16.Out_PfxDrop), 32'h0);
        send(16'h222A);
        check("ext_ext_drop", 32'(if16.Out_PfxDrop), EXT_EN ? 32'h1 : 32'h0);
        send(16'h0014);
        check("ext_ext_i4", 32'(if16.Out_Imm), EXT_EN ? 32'h2221 : 32'h0001);
        idle();

        send(16'hABCA);
        tb_in_valid = 1'b0;
        tb_reset    = 1'b1;
        tick();
        tb_reset = 1'b0;
        send(16'h0134);
        check("rst_pfx_imm", 32'(if16.Out_Imm), 32'h0003);
        check("rst_pfx_drop", 32'(if16.Out_PfxDrop), 32'h0);
        idle();

        send(16'hFEDA);
        send(16'h0A5C);
        check("j8_trunc16", 32'(if16.Out_Imm), EXT_EN ? 32'hEDA5 : 32'hFFA5);
        check("j8_sext32", if32.Out_Imm, EXT_EN ? 32'hFFFFEDA5 : 32'hFFFFFFA5);
        idle();

        send(16'h789A);
        idle();
        idle();
        send(16'h0034);
        check("pfx_stall_imm", 32'(if16.Out_Imm), EXT_EN ? 32'h7893 : 32'h0003);
        idle();
        idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
